// File: rtl/join_result_drain.sv
// -----------------------------------------------------------------------------
// join_result_drain
//
// Tail-end consumer of the join core chain's result path. Result pairs leaving
// the last join core stage are captured unconditionally whenever their valid
// bit (MSB) is set. They are buffered in a first-word-fall-through FIFO and
// presented downstream as an AXI4-Stream master with the valid bit stripped.
//
// The chain cannot be back-pressured combinationally. Instead, a registered
// stall is fed into the last stage's feedback input once occupancy reaches
// AFULL_THRESH. The space above the threshold absorbs the pairs that are
// still in flight while the stall ripples back through the stages.
//
// Parameters:
//   RESULT_PAIR_WIDTH  pair width; MSB = valid, low bits = payload
//   NUM_STAGES         join core stages in the chain (sets headroom)
//   FIFO_DEPTH         buffer entries; power of two, >= 2*NUM_STAGES+4
//   AFULL_THRESH       occupancy at or above which the stall is requested
//
// Ports:
//   aclk                          kernel clock
//   areset                        synchronous active-high reset
//   result_pair_input             pair from the last stage (valid = MSB)
//   result_stage_feedback_output  registered stall to the last stage
//   m_axis_tvalid/tready/tdata    AXI4-Stream master (payload only)
//   drain_idle                    FIFO empty and no valid input this cycle
//   overflow_sticky               a valid pair was dropped (cleared by reset)
//   result_count                  [JOIN_RESULT_DRAIN_COUNT_EN] pops, wraps
//   drop_count                    [JOIN_RESULT_DRAIN_COUNT_EN] drops, saturates
//
// Optional feature macro: JOIN_RESULT_DRAIN_COUNT_EN adds the two statistics
// counters and their ports. Without it, neither the ports nor the counters
// exist.
// -----------------------------------------------------------------------------
`ifndef PARA_RESULT_PAIR_WIDTH
`define PARA_RESULT_PAIR_WIDTH 65
`endif

module join_result_drain #(
    parameter int RESULT_PAIR_WIDTH = `PARA_RESULT_PAIR_WIDTH,
    parameter int NUM_STAGES        = 16,
    parameter int FIFO_DEPTH        = 64,
    parameter int AFULL_THRESH      = FIFO_DEPTH - 2*NUM_STAGES - 2
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [RESULT_PAIR_WIDTH-1:0] result_pair_input,
    output logic                         result_stage_feedback_output,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [RESULT_PAIR_WIDTH-2:0] m_axis_tdata,
    output logic                         drain_idle,
`ifdef JOIN_RESULT_DRAIN_COUNT_EN
    output logic [31:0]                  result_count,
    output logic [15:0]                  drop_count,
`endif
    output logic                         overflow_sticky
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = RESULT_PAIR_WIDTH - 1;

    // Storage and state
    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          feedback_q, feedback_d;
    logic          overflow_q, overflow_d;

    logic          in_valid;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    // NOTE: every signal driven here gets a value before any condition, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        in_valid   = result_pair_input[RESULT_PAIR_WIDTH-1];
        pop        = (count_q != '0) && m_axis_tready;
        full       = (count_q == CW'(FIFO_DEPTH));
        // A full FIFO still accepts a pair if the head leaves in the same cycle.
        push       = in_valid && (!full || pop);
        drop       = in_valid && full && !pop;

        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);

        // Stall follows next-state occupancy so it is asserted the cycle after
        // the threshold is reached, without waiting a further cycle.
        feedback_d = (count_d >= CW'(AFULL_THRESH));
        overflow_d = overflow_q || drop;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            feedback_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            feedback_q <= feedback_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; entries are only
    // observable through count_q, which is reset, so stale contents are never
    // presented and the array can map onto plain RAM.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= result_pair_input[DW-1:0];
        end
    end

    // First-word-fall-through: the head entry is always on tdata, and valid
    // comes from registered occupancy only (no input-to-output bypass).
    assign m_axis_tvalid                = (count_q != '0);
    assign m_axis_tdata                 = mem_q[rd_ptr_q];
    assign result_stage_feedback_output = feedback_q;
    assign overflow_sticky              = overflow_q;
    assign drain_idle                   = (count_q == '0) && !in_valid;

`ifdef JOIN_RESULT_DRAIN_COUNT_EN
    logic [31:0] result_count_q;
    logic [15:0] drop_count_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            result_count_q <= '0;
            drop_count_q   <= '0;
        end else begin
            if (pop) begin
                result_count_q <= result_count_q + 32'd1;
            end
            if (drop && (drop_count_q != 16'hFFFF)) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end

    assign result_count = result_count_q;
    assign drop_count   = drop_count_q;
`endif

endmodule

// File: tb/tb_join_result_drain.sv
// -----------------------------------------------------------------------------
// Testbench for join_result_drain (NUM_STAGES=4, FIFO_DEPTH=16, threshold 6,
// 65-bit pairs). The stimulus side keeps a small occupancy model and pushes
// every pair it expects to be stored into a scoreboard queue. A monitor on
// the falling edge compares each presented output against the queue head.
// -----------------------------------------------------------------------------
module tb_join_result_drain;

    localparam int W      = 65;
    localparam int NS     = 4;
    localparam int D      = 16;
    localparam int THRESH = 6;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [W-1:0]  result_pair_input = '0;
    logic          m_axis_tready = 1'b0;
    logic          feedback;
    logic          m_axis_tvalid;
    logic [W-2:0]  m_axis_tdata;
    logic          drain_idle;
    logic          overflow_sticky;
`ifdef JOIN_RESULT_DRAIN_COUNT_EN
    logic [31:0]   result_count;
    logic [15:0]   drop_count;
`endif

    join_result_drain #(
        .RESULT_PAIR_WIDTH (W),
        .NUM_STAGES        (NS),
        .FIFO_DEPTH        (D)
    ) dut (
        .aclk                         (aclk),
        .areset                       (areset),
        .result_pair_input            (result_pair_input),
        .result_stage_feedback_output (feedback),
        .m_axis_tvalid                (m_axis_tvalid),
        .m_axis_tready                (m_axis_tready),
        .m_axis_tdata                 (m_axis_tdata),
        .drain_idle                   (drain_idle),
`ifdef JOIN_RESULT_DRAIN_COUNT_EN
        .result_count                 (result_count),
        .drop_count                   (drop_count),
`endif
        .overflow_sticky              (overflow_sticky)
    );

    always #5 aclk = ~aclk;

    int            n_checks  = 0;
    int            n_errors  = 0;
    logic [63:0]   exp_q[$];
    int            m_count   = 0;
    bit            exp_ovf   = 1'b0;
    int            exp_drops = 0;
    longint        exp_pops  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge when tvalid and
    // tready are both high at the falling edge.
    always @(negedge aclk) begin
        if (!areset && m_axis_tvalid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got 0x%0h with empty scoreboard at %0t",
                         m_axis_tdata, $time);
            end else if (m_axis_tready) begin
                check("stream_data", m_axis_tdata, exp_q.pop_front());
            end else begin
                check("hold_data", m_axis_tdata, exp_q[0]);
            end
        end
    end

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic cycle(input bit v, input logic [63:0] d, input bit rdy);
        bit pop;
        result_pair_input = v ? {1'b1, d} : '0;
        m_axis_tready     = rdy;
        pop = (m_count != 0) && rdy;
        if (v) begin
            if (m_count < D || pop) begin
                exp_q.push_back(d);
                m_count++;
            end else begin
                exp_ovf = 1'b1;
                if (exp_drops < 65535) exp_drops++;
            end
        end
        if (pop) begin
            m_count--;
            exp_pops++;
        end
        @(posedge aclk);
        #1;
        check("tvalid", m_axis_tvalid, 64'(m_count != 0));
        check("feedback", feedback, 64'(m_count >= THRESH));
        check("overflow", overflow_sticky, 64'(exp_ovf));
`ifdef JOIN_RESULT_DRAIN_COUNT_EN
        check("result_count", result_count, 64'(exp_pops));
        check("drop_count", drop_count, 64'(exp_drops));
`endif
    endtask

    task automatic idle_check();
        result_pair_input = '0;
        #1;
        check("drain_idle", drain_idle, 64'(m_count == 0));
    endtask

    task automatic drain();
        for (int i = 0; i < 4*D && m_count != 0; i++) cycle(1'b0, 64'h0, 1'b1);
        check("drained", 64'(exp_q.size()), 64'h0);
        idle_check();
    endtask

    task automatic do_reset();
        result_pair_input = '0;
        m_axis_tready     = 1'b0;
        areset            = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        exp_q.delete();
        m_count   = 0;
        exp_ovf   = 1'b0;
        exp_drops = 0;
        exp_pops  = 0;
        check("rst_tvalid", m_axis_tvalid, 64'h0);
        check("rst_feedback", feedback, 64'h0);
        check("rst_overflow", overflow_sticky, 64'h0);
        check("rst_drain_idle", drain_idle, 64'h1);
`ifdef JOIN_RESULT_DRAIN_COUNT_EN
        check("rst_result_count", result_count, 64'h0);
        check("rst_drop_count", drop_count, 64'h0);
`endif
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge aclk);
        #1;
        do_reset();

        // Basic flow: one pair straight through with tready held high
        result_pair_input = {1'b1, 64'h0000_0000_0000_00AA};
        m_axis_tready     = 1'b1;
        #1;
        check("drain_idle_busy", drain_idle, 64'h0);
        cycle(1'b1, 64'hAA, 1'b1);
        cycle(1'b0, 64'h0, 1'b1);
        idle_check();

        // Stall threshold: rises after the 6th push, falls after one pop
        for (int i = 1; i <= 6; i++) cycle(1'b1, 64'(i), 1'b0);
        cycle(1'b0, 64'h0, 1'b1);
        drain();

        // Headroom: 16 pushes all stored, no overflow
        for (int i = 1; i <= 16; i++) cycle(1'b1, 64'(i), 1'b0);
        drain();

        // Overflow: 17th pair dropped
        for (int i = 1; i <= 17; i++) cycle(1'b1, 64'(i), 1'b0);
        check("overflow_set", overflow_sticky, 64'h1);
        drain();

        // Full with simultaneous push and pop
        for (int i = 1; i <= 16; i++) cycle(1'b1, 64'h100 + 64'(i), 1'b0);
        cycle(1'b1, 64'h55, 1'b1);
        drain();

        // Reset mid-operation with 10 entries buffered
        for (int i = 1; i <= 10; i++) cycle(1'b1, 64'h200 + 64'(i), 1'b0);
        do_reset();
        cycle(1'b0, 64'h0, 1'b1);
        cycle(1'b1, 64'h77, 1'b0);
        cycle(1'b1, 64'h78, 1'b1);
        drain();

        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
